// File: rtl/vend_session_arbiter_pkg.sv
// Shared definitions for the vending-machine session arbiter.
//   - machine command codes (one-hot vm_inpco values)
//   - machine / response codes returned to panels, including the arbiter's REJECT
//   - machine credit-state encodings
//   - session FSM state type
//   - one-hot command check used by the arbiter FSM
package vend_session_arbiter_pkg;

  // Machine command codes.
  localparam logic [3:0] INPCO_NONE   = 4'b0000;
  localparam logic [3:0] INPCO_IN050  = 4'b0001;
  localparam logic [3:0] INPCO_IN100  = 4'b0010;
  localparam logic [3:0] INPCO_COFFEE = 4'b0100;
  localparam logic [3:0] INPCO_RETBUT = 4'b1000;

  // Vending result codes; REJECT is produced by the arbiter, never by the machine.
  localparam logic [2:0] VEND_IDLE   = 3'b000;
  localparam logic [2:0] VEND_PASS   = 3'b001;
  localparam logic [2:0] VEND_VENCOF = 3'b010;
  localparam logic [2:0] VEND_RETWON = 3'b100;
  localparam logic [2:0] VEND_REJECT = 3'b111;

  // Machine credit states: 0 / 50 / 100 / 150.
  localparam logic [1:0] CREDIT_000 = 2'b00;
  localparam logic [1:0] CREDIT_050 = 2'b01;
  localparam logic [1:0] CREDIT_100 = 2'b10;
  localparam logic [1:0] CREDIT_150 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OWNED = 3'd3,
    ST_REJ   = 3'd4
  } state_e;

  // Only single-bit commands are meaningful to the machine.
  function automatic logic cmd_is_onehot(input logic [3:0] cmd);
    return $onehot(cmd);
  endfunction

endpackage

// File: rtl/vend_session_arbiter_if.sv
// Bundle between the customer panels / vending machine and the session arbiter.
//   req_valid/req_cmd/req_ready : per-panel command handshake (4 bits per panel)
//   vm_inpco                    : one-cycle command pulse to the machine
//   vm_vending/vm_state         : machine result and credit state
//   rsp_valid/rsp_code          : one-cycle result pulse to the session owner
//   owner/busy                  : current session owner (one-hot) and activity flag
// master = panels + machine side, slave = arbiter side.
interface vend_session_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_cmd;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        vm_inpco;
  logic [2:0]        vm_vending;
  logic [1:0]        vm_state;
  logic [NREQ-1:0]   rsp_valid;
  logic [2:0]        rsp_code;
  logic [NREQ-1:0]   owner;
  logic              busy;

  modport master (
    output req_valid, req_cmd, vm_vending, vm_state,
    input  req_ready, vm_inpco, rsp_valid, rsp_code, owner, busy
  );

  modport slave (
    input  req_valid, req_cmd, vm_vending, vm_state,
    output req_ready, vm_inpco, rsp_valid, rsp_code, owner, busy
  );
endinterface

// File: rtl/vend_session_arbiter_rr.sv
// Round-robin request selector (combinational).
//   req_i       : request vector
//   ptr_i       : index with highest priority this round
//   grant_o     : one-hot grant, first request at or after ptr_i, wrapping
//   grant_idx_o : index of the granted request
//   any_o       : at least one request present
module vend_session_arbiter_rr #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            any_o
);
  logic [IW-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[idx]) begin
        any_o       = 1'b1;
        grant_o     = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o = idx;
      end
    end
  end
endmodule

// File: rtl/vend_session_arbiter.sv
// Shares one vending-machine datapath between NREQ panels, one session at a time.
// A panel granted from IDLE owns the machine until its credit returns to zero;
// each command becomes a single-cycle vm_inpco pulse and the machine's result is
// returned to the owner. Non-one-hot commands are rejected; an owner that stays
// silent for TIMEOUT cycles gets a forced RETBUT.
//   clock_i  : system clock, rising edge
//   reset_ni : asynchronous active-low reset
//   sess_if  : panel handshake, machine command/status and session status (slave)
module vend_session_arbiter
  import vend_session_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input logic                   clock_i,
  input logic                   reset_ni,
  vend_session_arbiter_if.slave sess_if
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e          state_q;
  logic [NREQ-1:0] owner_q;
  logic [IW-1:0]   owner_idx_q;
  logic [IW-1:0]   ptr_q;
  logic [TW-1:0]   timer_q;
  logic [3:0]      vm_inpco_q;
  logic [NREQ-1:0] req_ready_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [2:0]      rsp_code_q;
  logic            busy_q;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [3:0]      grant_cmd;
  logic            own_valid;
  logic [3:0]      own_cmd;
  logic [IW-1:0]   ptr_after_owner;

  vend_session_arbiter_rr #(.NREQ(NREQ)) u_rr (
    .req_i       (sess_if.req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign grant_cmd = sess_if.req_cmd[{grant_idx, 2'b00} +: 4];
  // While a session is open only the owner's panel is looked at.
  assign own_valid = |(sess_if.req_valid & owner_q);
  assign own_cmd   = sess_if.req_cmd[{owner_idx_q, 2'b00} +: 4];
  // Next round starts just after the panel whose session is ending.
  assign ptr_after_owner = (owner_idx_q == IW'(NREQ - 1)) ? '0 : owner_idx_q + IW'(1);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      owner_idx_q <= '0;
      ptr_q       <= '0;
      timer_q     <= '0;
      vm_inpco_q  <= INPCO_NONE;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_code_q  <= VEND_IDLE;
      busy_q      <= 1'b0;
    end else begin
      // Pulse outputs default low; the state that needs them raises them for one cycle.
      vm_inpco_q  <= INPCO_NONE;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_code_q  <= VEND_IDLE;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            owner_q     <= grant;
            owner_idx_q <= grant_idx;
            req_ready_q <= grant;
            busy_q      <= 1'b1;
            if (cmd_is_onehot(grant_cmd)) begin
              vm_inpco_q <= grant_cmd;
              timer_q    <= '0;
              state_q    <= ST_ISSUE;
            end else begin
              rsp_valid_q <= grant;
              rsp_code_q  <= VEND_REJECT;
              state_q     <= ST_REJ;
            end
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          // The machine registered the command at the end of ISSUE, so its result is current now.
          rsp_valid_q <= owner_q;
          rsp_code_q  <= sess_if.vm_vending;
          if (sess_if.vm_state == CREDIT_000) begin
            owner_q <= '0;
            ptr_q   <= ptr_after_owner;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= '0;
            state_q <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          // An owner request beats a timeout expiring in the same cycle.
          if (own_valid) begin
            timer_q     <= '0;
            req_ready_q <= owner_q;
            if (cmd_is_onehot(own_cmd)) begin
              vm_inpco_q <= own_cmd;
              state_q    <= ST_ISSUE;
            end else begin
              rsp_valid_q <= owner_q;
              rsp_code_q  <= VEND_REJECT;
              state_q     <= ST_REJ;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            // Forced credit return: the panel did not ask, so it gets no req_ready.
            timer_q    <= '0;
            vm_inpco_q <= INPCO_RETBUT;
            state_q    <= ST_ISSUE;
          end else if (timer_q != {TW{1'b1}}) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_REJ: begin
          if (sess_if.vm_state == CREDIT_000) begin
            owner_q <= '0;
            ptr_q   <= ptr_after_owner;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_OWNED;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sess_if.vm_inpco  = vm_inpco_q;
  assign sess_if.req_ready = req_ready_q;
  assign sess_if.rsp_valid = rsp_valid_q;
  assign sess_if.rsp_code  = rsp_code_q;
  assign sess_if.owner     = owner_q;
  assign sess_if.busy      = busy_q;
endmodule

// File: tb/tb_vend_session_arbiter.sv
// Bench for vend_session_arbiter with NREQ=2, TIMEOUT=4 and a behavioural vending machine.
module tb_vend_session_arbiter;
  import vend_session_arbiter_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vend_session_arbiter_if #(.NREQ(NREQ)) sess();

  vend_session_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .sess_if  (sess)
  );

  // Vending machine: registered, coffee costs 100, overflowing coins are passed back.
  logic [1:0] credit_q;
  logic [2:0] vend_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CREDIT_000;
      vend_q   <= VEND_IDLE;
    end else begin
      case (sess.vm_inpco)
        INPCO_IN050:
          if (credit_q == CREDIT_150) vend_q <= VEND_PASS;
          else begin credit_q <= credit_q + 2'd1; vend_q <= VEND_IDLE; end
        INPCO_IN100:
          if (credit_q >= CREDIT_100) vend_q <= VEND_PASS;
          else begin credit_q <= credit_q + 2'd2; vend_q <= VEND_IDLE; end
        INPCO_COFFEE:
          if (credit_q >= CREDIT_100) begin credit_q <= credit_q - 2'd2; vend_q <= VEND_VENCOF; end
          else vend_q <= VEND_IDLE;
        INPCO_RETBUT:
          if (credit_q != CREDIT_000) begin credit_q <= CREDIT_000; vend_q <= VEND_RETWON; end
          else vend_q <= VEND_IDLE;
        default: vend_q <= VEND_IDLE;
      endcase
    end
  end
  assign sess.vm_vending = vend_q;
  assign sess.vm_state   = credit_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sess.req_valid = '0;
    sess.req_cmd   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] v;
    logic [7:0] cmd;
    logic [1:0] own;
    logic       busy;
    logic [3:0] inp;
    logic [1:0] rdy;
    logic [1:0] rv;
    logic [2:0] code;
    logic [1:0] st;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [1:0] v, logic [7:0] cmd, logic [1:0] own, logic busy,
                              logic [3:0] inp, logic [1:0] rdy, logic [1:0] rv, logic [2:0] code,
                              logic [1:0] st);
    vec_t r;
    r.rst = rst; r.v = v; r.cmd = cmd; r.own = own; r.busy = busy;
    r.inp = inp; r.rdy = rdy; r.rv = rv; r.code = code; r.st = st;
    return r;
  endfunction

  vec_t       vecs[$];
  int         fair_n;
  logic [1:0] fair_last;
  logic [1:0] fair_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each row: inputs applied, one clock edge, then the expected outputs and machine credit.
    //            rst v      cmd    own   b  inp   rdy   rv    code  st
    // single vend: IN100 then COFFEE
    vecs.push_back(mk(1, 2'b01, 8'h02, 2'b01, 1, 4'h2, 2'b01, 2'b00, 3'd0, 2'd0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b01, 3'd0, 2'd2));
    vecs.push_back(mk(0, 2'b01, 8'h04, 2'b01, 1, 4'h4, 2'b01, 2'b00, 3'd0, 2'd2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b00, 0, 4'h0, 2'b00, 2'b01, 3'd2, 2'd0));
    // contention: both IN050, p0 wins, p0 RETBUT, then p1 granted
    vecs.push_back(mk(1, 2'b11, 8'h11, 2'b01, 1, 4'h1, 2'b01, 2'b00, 3'd0, 2'd0));
    vecs.push_back(mk(0, 2'b10, 8'h10, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b10, 8'h10, 2'b01, 1, 4'h0, 2'b00, 2'b01, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b11, 8'h18, 2'b01, 1, 4'h8, 2'b01, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b10, 8'h10, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd0));
    vecs.push_back(mk(0, 2'b10, 8'h10, 2'b00, 0, 4'h0, 2'b00, 2'b01, 3'd4, 2'd0));
    vecs.push_back(mk(0, 2'b10, 8'h10, 2'b10, 1, 4'h1, 2'b10, 2'b00, 3'd0, 2'd0));
    // timeout: p1 stays silent for 4 OWNED cycles, forced RETBUT without req_ready
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b10, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b10, 1, 4'h0, 2'b00, 2'b10, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b10, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b10, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b10, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b10, 1, 4'h8, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b10, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b00, 0, 4'h0, 2'b00, 2'b10, 3'd4, 2'd0));
    // reject while owning 50: 0011 gives ready + REJECT, credit kept, back to OWNED
    vecs.push_back(mk(1, 2'b01, 8'h01, 2'b01, 1, 4'h1, 2'b01, 2'b00, 3'd0, 2'd0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b01, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b01, 8'h03, 2'b01, 1, 4'h0, 2'b01, 2'b01, 3'd7, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    // reject straight from IDLE: no credit, so the session ends at once
    vecs.push_back(mk(1, 2'b10, 8'h60, 2'b10, 1, 4'h0, 2'b10, 2'b10, 3'd7, 2'd0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b00, 0, 4'h0, 2'b00, 2'b00, 3'd0, 2'd0));
    // owner request in the same cycle the timer expires: request wins
    vecs.push_back(mk(1, 2'b01, 8'h01, 2'b01, 1, 4'h1, 2'b01, 2'b00, 3'd0, 2'd0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b01, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b01, 8'h02, 2'b01, 1, 4'h2, 2'b01, 2'b00, 3'd0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b00, 3'd0, 2'd3));
    vecs.push_back(mk(0, 2'b00, 8'h00, 2'b01, 1, 4'h0, 2'b00, 2'b01, 3'd0, 2'd3));

    sess.req_valid = '0;
    sess.req_cmd   = '0;

    // Reset state, then an asynchronous reset landing in WAIT.
    repeat (2) @(posedge clk);
    #1;
    chk("reset owner", 32'(sess.owner), 32'h0);
    chk("reset busy", 32'(sess.busy), 32'h0);
    chk("reset inpco", 32'(sess.vm_inpco), 32'h0);
    chk("reset rsp_valid", 32'(sess.rsp_valid), 32'h0);
    chk("reset req_ready", 32'(sess.req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sess.req_valid = 2'b01;
    sess.req_cmd   = 8'h02;
    @(posedge clk); #1;
    sess.req_valid = '0;
    @(posedge clk); #1;
    chk("wait busy", 32'(sess.busy), 32'h1);
    chk("wait owner", 32'(sess.owner), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset owner", 32'(sess.owner), 32'h0);
    chk("midreset busy", 32'(sess.busy), 32'h0);
    chk("midreset inpco", 32'(sess.vm_inpco), 32'h0);
    chk("midreset rsp_valid", 32'(sess.rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after release busy", 32'(sess.busy), 32'h0);
    chk("after release rsp_valid", 32'(sess.rsp_valid), 32'h0);
    chk("after release owner", 32'(sess.owner), 32'h0);
    $display("reset sequence: busy=%0b owner=%b", sess.busy, sess.owner);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      sess.req_valid = vecs[i].v;
      sess.req_cmd   = vecs[i].cmd;
      @(posedge clk); #1;
      chk($sformatf("v%0d owner", i), 32'(sess.owner), 32'(vecs[i].own));
      chk($sformatf("v%0d busy", i), 32'(sess.busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d inpco", i), 32'(sess.vm_inpco), 32'(vecs[i].inp));
      chk($sformatf("v%0d req_ready", i), 32'(sess.req_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d rsp_valid", i), 32'(sess.rsp_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d rsp_code", i), 32'(sess.rsp_code), 32'(vecs[i].code));
      chk($sformatf("v%0d vm_state", i), 32'(sess.vm_state), 32'(vecs[i].st));
      $display("vec %0d: v=%b cmd=%h owner=%b inpco=%b ready=%b rsp=%b/%b state=%b",
               i, vecs[i].v, vecs[i].cmd, sess.owner, sess.vm_inpco, sess.req_ready,
               sess.rsp_valid, sess.rsp_code, sess.vm_state);
    end

    // Fairness: both panels keep asking for RETBUT with zero credit.
    do_reset();
    sess.req_valid = 2'b11;
    sess.req_cmd   = 8'h88;
    fair_n    = 0;
    fair_last = 2'b00;
    for (int cyc = 0; cyc < 40 && fair_n < 4; cyc++) begin
      @(posedge clk); #1;
      if (sess.rsp_valid != 2'b00) begin
        chk($sformatf("fair rsp_valid %0d", fair_n), 32'(sess.rsp_valid), 32'(fair_last));
        chk($sformatf("fair rsp_code %0d", fair_n), 32'(sess.rsp_code), 32'(VEND_IDLE));
        $display("fair rsp: valid=%b code=%b", sess.rsp_valid, sess.rsp_code);
      end
      if (sess.req_ready != 2'b00) begin
        fair_exp = (fair_n % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("fair grant %0d", fair_n), 32'(sess.req_ready), 32'(fair_exp));
        $display("fair grant %0d: ready=%b inpco=%b", fair_n, sess.req_ready, sess.vm_inpco);
        fair_last = sess.req_ready;
        fair_n++;
      end
    end
    if (fair_n < 4) chk("fair grant count", 32'(fair_n), 32'd4);
    sess.req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
